// File: rtl/testeio_pio_in_edge_if.sv
// rtl/testeio_pio_in_edge_if.sv - Avalon-MM slave register bus for the edge-capturing PIO input port
interface testeio_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/testeio_pio_in_edge.sv
// rtl/testeio_pio_in_edge.sv - PIO input port with synchroniser, per-bit edge capture, irq mask and irq
module testeio_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  testeio_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_pipe_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits have no register behind them.
  assign unused_wdata = ^bus.writedata;

  assign sync_q = sync_pipe_q[SYNC_STAGES-1];
  assign wr_en  = bus.chipselect & ~bus.write_n;

  // Metastability chain per bit; the last stage feeds everything downstream.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_pipe_q[i] <= '0;
      end
    end else begin
      sync_pipe_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_pipe_q[i] <= sync_pipe_q[i-1];
      end
    end
  end

  // Edge selection and next-state for capture, mask and read mux.
  always_comb begin
    edge_hit   = '0;
    cap_clr    = '0;
    readdata_d = '0;
    case (EDGE_TYPE)
      0:       edge_hit = sync_q & ~prev_q;
      1:       edge_hit = ~sync_q & prev_q;
      default: edge_hit = (sync_q & ~prev_q) | (~sync_q & prev_q);
    endcase
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      cap_clr = bus.writedata[WIDTH-1:0];
    end
    // A fresh edge in the same cycle as a clear keeps the bit set.
    edgecap_d = (edgecap_q & ~cap_clr) | edge_hit;
    irqmask_d = irqmask_q;
    if (wr_en && (bus.address == ADDR_IRQMASK)) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end
    case (bus.address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  // State registers; readdata reloads every cycle so reads have fixed latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= sync_q;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  generate
    if (IRQ_MODE == 1) begin : g_irq_edge
      assign irq = |(edgecap_q & irqmask_q);
    end else begin : g_irq_level
      assign irq = |(sync_q & irqmask_q);
    end
  endgenerate

endmodule

// File: tb/tb_testeio_pio_in_edge.sv
// tb/tb_testeio_pio_in_edge.sv - scoreboard bench for the edge-capturing PIO input port
module tb_testeio_pio_in_edge;
  localparam int N = 2;

  typedef struct {
    int          due;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_port;
  logic       irq_a, irq_b;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  exp_t       sb_q[$];

  // reference model: history of inputs plus architectural register values
  logic [7:0] hist [0:4095];
  int         last_rst = 0;
  int         e_next = 1;
  logic [7:0] m_sync = 8'h00, m_prev = 8'h00;
  logic [7:0] m_cap_a = 8'h00, m_cap_b = 8'h00, m_mask = 8'h00;
  logic [7:0] cur_in = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  testeio_pio_in_edge_if bus_a ();
  testeio_pio_in_edge_if bus_b ();

  testeio_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(N), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a),
    .in_port (in_port),
    .irq     (irq_a)
  );

  testeio_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(N), .EDGE_TYPE(2), .IRQ_MODE(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b),
    .in_port (in_port),
    .irq     (irq_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs for the coming edge, advance the model, queue expectations.
  task automatic step(input logic rst_n, input logic [7:0] din, input logic cs, input logic wn,
                      input logic [1:0] addr, input logic [31:0] wd);
    exp_t       x;
    logic [7:0] rise, fall, clr, ns;
    int         e;
    reset_n = rst_n;
    in_port = din;
    bus_a.address = addr;  bus_b.address = addr;
    bus_a.chipselect = cs; bus_b.chipselect = cs;
    bus_a.write_n = wn;    bus_b.write_n = wn;
    bus_a.writedata = wd;  bus_b.writedata = wd;
    e = e_next;
    hist[e] = din;
    if (!rst_n) begin
      last_rst = e;
      m_sync = 8'h00; m_prev = 8'h00;
      m_cap_a = 8'h00; m_cap_b = 8'h00; m_mask = 8'h00;
      x.rd_a = 32'h0; x.rd_b = 32'h0;
    end else begin
      case (addr)
        2'd0:    begin x.rd_a = {24'h0, m_sync};  x.rd_b = {24'h0, m_sync};  end
        2'd2:    begin x.rd_a = {24'h0, m_mask};  x.rd_b = {24'h0, m_mask};  end
        2'd3:    begin x.rd_a = {24'h0, m_cap_a}; x.rd_b = {24'h0, m_cap_b}; end
        default: begin x.rd_a = 32'h0;            x.rd_b = 32'h0;            end
      endcase
      rise = m_sync & ~m_prev;
      fall = ~m_sync & m_prev;
      clr  = (cs && !wn && addr == 2'd3) ? wd[7:0] : 8'h00;
      m_cap_a = (m_cap_a & ~clr) | rise;
      m_cap_b = (m_cap_b & ~clr) | rise | fall;
      if (cs && !wn && addr == 2'd2) m_mask = wd[7:0];
      // synchronised value seen N-1 edges after the input was applied, zero until the pipe refills
      ns = (e - (N - 1) > last_rst) ? hist[e-(N-1)] : 8'h00;
      m_prev = m_sync;
      m_sync = ns;
    end
    x.irq_a = |(m_cap_a & m_mask);
    x.irq_b = |(m_sync & m_mask);
    x.due   = e;
    sb_q.push_back(x);
    e_next++;
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, cur_in, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, cur_in, 1'b1, 1'b0, a, d);
  endtask

  // monitor: compare every output sample against the queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        x = sb_q.pop_front();
        chk("rd_a", bus_a.readdata, x.rd_a);
        chk("rd_b", bus_b.readdata, x.rd_b);
        chk("irq_a", {31'h0, irq_a}, {31'h0, x.irq_a});
        chk("irq_b", {31'h0, irq_b}, {31'h0, x.irq_b});
      end
    end
  end

  initial begin
    logic       r;
    logic       cs, wn;
    logic [1:0] a;
    // reset and idle read-back
    cur_in = 8'h00;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) rd(i[1:0]);
    rd(2'd2);
    chk("reset_mask", bus_a.readdata, 32'h0);
    chk("reset_irq", {31'h0, irq_a}, 32'h0);

    // rising capture
    cur_in = 8'h05;
    repeat (4) rd(2'd3);
    chk("rise_cap", bus_a.readdata, 32'h05);
    rd(2'd0);
    chk("rise_data", bus_a.readdata, 32'h05);
    chk("rise_irq_unmasked", {31'h0, irq_a}, 32'h0);

    // mask then clear
    wr(2'd2, 32'h04);
    chk("mask_irq", {31'h0, irq_a}, 32'h1);
    wr(2'd3, 32'h04);
    chk("clear_irq", {31'h0, irq_a}, 32'h0);
    rd(2'd3);
    chk("clear_cap", bus_a.readdata, 32'h01);

    // set-wins race on bit 1
    cur_in = 8'h07; repeat (3) rd(2'd0);
    cur_in = 8'h05; repeat (3) rd(2'd0);
    wr(2'd3, 32'h02);
    cur_in = 8'h07;
    rd(2'd0);
    rd(2'd0);
    wr(2'd3, 32'h02);
    rd(2'd3);
    chk("set_wins", bus_a.readdata, 32'h03);

    // any-edge capture and level irq on bit 7
    wr(2'd2, 32'h80);
    cur_in = 8'h87; repeat (3) rd(2'd0);
    chk("level_irq_high", {31'h0, irq_b}, 32'h1);
    wr(2'd3, 32'hFF);
    cur_in = 8'h07; repeat (3) rd(2'd0);
    chk("level_irq_low", {31'h0, irq_b}, 32'h0);
    rd(2'd3);
    chk("fall_cap_b", bus_b.readdata, 32'h80);

    // reset mid-operation
    wr(2'd2, 32'hFF);
    wr(2'd3, 32'hFF);
    cur_in = 8'h00; repeat (3) rd(2'd0);
    cur_in = 8'hFF; repeat (4) rd(2'd3);
    chk("full_cap", bus_a.readdata, 32'hFF);
    cur_in = 8'h00;
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h0);
    chk("mid_reset_irq_a", {31'h0, irq_a}, 32'h0);
    chk("mid_reset_irq_b", {31'h0, irq_b}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0]);
      chk("mid_reset_rd", bus_a.readdata, 32'h0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) cur_in = cur_in ^ 8'($urandom);
      cs = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 3) != 0);
      a  = 2'($urandom_range(0, 3));
      step(r, cur_in, cs, wn, a, $urandom);
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
